// File: rtl/nes_pad_emulator_pkg.sv
// Shared definitions for the NES/SNES pad emulator: frame size, button bit
// positions (these match the pad-reader's nesState[11:0]), FSM state
// encoding and the frame-word builder.
package nes_pad_emulator_pkg;

  localparam int NES_FRAME_BITS = 16;

  // Button bit indices inside the 12-bit button vector.
  localparam int NES_BTN_B      = 0;
  localparam int NES_BTN_Y      = 1;
  localparam int NES_BTN_SELECT = 2;
  localparam int NES_BTN_START  = 3;
  localparam int NES_BTN_UP     = 4;
  localparam int NES_BTN_DOWN   = 5;
  localparam int NES_BTN_LEFT   = 6;
  localparam int NES_BTN_RIGHT  = 7;
  localparam int NES_BTN_A      = 8;
  localparam int NES_BTN_X      = 9;
  localparam int NES_BTN_L      = 10;
  localparam int NES_BTN_R      = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } nes_state_e;

  // The wire is active-low for buttons; the pad ID nibble is sent raw.
  function automatic logic [NES_FRAME_BITS-1:0] nes_frame_word(
    input logic [3:0]  pad_id,
    input logic [11:0] buttons
  );
    return {pad_id, ~buttons};
  endfunction

endpackage

// File: rtl/nes_pad_emulator_line_sync.sv
// Brings one asynchronous host line into the clk domain: a flop
// synchronizer, then a glitch filter that only accepts a new level after it
// has been seen on FILTER_LEN consecutive synced samples. Rise/fall pulses
// are registered and come out on the same edge the filtered level flips.
module nes_pad_emulator_line_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 3,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  logic w_synced;
  logic w_differs;
  logic w_accept;

  assign w_synced  = r_sync[SYNC_STAGES-1];
  assign w_differs = (w_synced != r_level);
  // The current sample is the FILTER_LEN-th in a row that disagrees.
  assign w_accept  = w_differs && (r_cnt == CW'(FILTER_LEN - 1));

  // Metastability chain; resets to the line's idle level.
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_sync <= {SYNC_STAGES{RST_VAL}};
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
  end

  // Run-length filter on the synced level plus edge pulses.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_level <= RST_VAL;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_accept &&  w_synced;
      r_fall <= w_accept && !w_synced;
      if (w_accept) begin
        r_level <= w_synced;
        r_cnt   <= '0;
      end else if (w_differs) begin
        r_cnt   <= r_cnt + CW'(1);
      end else begin
        r_cnt   <= '0;
      end
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/nes_pad_emulator.sv
// Controller side of the NES/SNES pad serial link. The host latches, then
// clocks 16 bits out LSB first; we present the active-low button image plus
// a raw pad ID nibble. Shifting happens on the host's rising nesc so each
// bit is settled well before the host samples on the following fall.
module nes_pad_emulator
  import nes_pad_emulator_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3,
  parameter logic [3:0] PAD_ID      = 4'h0,
  parameter int         TIMEOUT     = 25000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_nesl,
  input  logic        i_nesc,
  output logic        o_nesd,
  input  logic [11:0] i_buttons,
  output logic        o_frame_done,
  output logic        o_link_active
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic w_l_rise;
  logic w_l_fall;
  logic w_c_rise;
  logic w_unused_c_fall;

  // Latch idles low, shift clock idles high.
  nes_pad_emulator_line_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .RST_VAL    (1'b0)
  ) u_sync_latch (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_pin  (i_nesl),
    .o_rise (w_l_rise),
    .o_fall (w_l_fall)
  );

  nes_pad_emulator_line_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .RST_VAL    (1'b1)
  ) u_sync_clock (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_pin  (i_nesc),
    .o_rise (w_c_rise),
    .o_fall (w_unused_c_fall)
  );

  nes_state_e                r_state;
  nes_state_e                w_state_nxt;
  logic [NES_FRAME_BITS-1:0] r_shreg;
  logic [NES_FRAME_BITS-1:0] w_shreg_nxt;
  logic [4:0]                r_bit_cnt;
  logic [4:0]                w_bit_cnt_nxt;
  logic                      r_frame_done;
  logic                      w_frame_done_nxt;
  logic [TW-1:0]             r_to_cnt;
  logic                      r_link_active;
  logic [NES_FRAME_BITS-1:0] w_load_word;

  assign w_load_word = nes_frame_word(PAD_ID, i_buttons);

  // FSM state, shift register, bit counter and done pulse.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '1;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Next-state logic. A latch rise restarts the frame from any state and
  // beats a simultaneous nesc rise. Ones are shifted in from the top, so
  // after 16 shifts (and in IDLE after reset) the line idles high.
  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_frame_done_nxt = 1'b0;
    if (w_l_rise) begin
      w_state_nxt   = ST_LOAD;
      w_shreg_nxt   = w_load_word;
      w_bit_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_LOAD: begin
          // Keep tracking the buttons until the latch drops.
          w_shreg_nxt   = w_load_word;
          w_bit_cnt_nxt = '0;
          if (w_l_fall) w_state_nxt = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_c_rise) begin
            w_shreg_nxt   = {1'b1, r_shreg[NES_FRAME_BITS-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'(NES_FRAME_BITS - 1)) begin
              w_frame_done_nxt = 1'b1;
              w_state_nxt      = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Link watchdog: restarted by each latch, saturates at TIMEOUT.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_to_cnt      <= '0;
      r_link_active <= 1'b0;
    end else if (w_l_rise) begin
      r_to_cnt      <= '0;
      r_link_active <= 1'b1;
    end else if (r_to_cnt != TW'(TIMEOUT)) begin
      r_to_cnt <= r_to_cnt + TW'(1);
      if (r_to_cnt == TW'(TIMEOUT - 1)) r_link_active <= 1'b0;
    end
  end

  assign o_nesd        = r_shreg[0];
  assign o_frame_done  = r_frame_done;
  assign o_link_active = r_link_active;

endmodule
